// File: rtl/dmi_arbiter.sv
// Two-port round-robin arbiter in front of a single DMI port: one transaction in flight,
// responses routed back to the issuing requester, hung DM accesses turned into failures.
module dmi_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_data,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [1:0]        resp0_resp,
    output logic [DATA_W-1:0] resp0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_data,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [1:0]        resp1_resp,
    output logic [DATA_W-1:0] resp1_data,

    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic [ADDR_W-1:0] dm_req_addr,
    output logic [1:0]        dm_req_op,
    output logic [DATA_W-1:0] dm_req_data,
    input  logic              dm_resp_valid,
    output logic              dm_resp_ready,
    input  logic [1:0]        dm_resp_resp,
    input  logic [DATA_W-1:0] dm_resp_data,

    output logic              timeout_pulse
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DELIVER
    } state_t;

    state_t              state, state_next;
    logic                prio;      // port preferred on a tie (the one not granted last)
    logic                owner;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          resp_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    cnt;

    logic grant0, grant1, accept, timeout_hit, owner_ready;

    assign grant0      = req0_valid && (!req1_valid || !prio);
    assign grant1      = req1_valid && (!req0_valid ||  prio);
    assign accept      = (state == S_IDLE) && (grant0 || grant1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign owner_ready = owner ? resp1_ready : resp0_ready;

    // NOTE: clocked processes use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (accept)                               state_next = S_REQ;
            S_REQ:     if (dm_req_ready)                         state_next = S_RESP;
            S_RESP:    if (dm_resp_valid || timeout_hit)         state_next = S_DELIVER;
            S_DELIVER: if (owner_ready)                          state_next = S_IDLE;
            default:                                             state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        dm_req_valid  = 1'b0;
        resp0_valid   = 1'b0;
        resp1_valid   = 1'b0;
        timeout_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
            end
            S_REQ:     dm_req_valid  = 1'b1;
            S_RESP:    timeout_pulse = timeout_hit && !dm_resp_valid;
            S_DELIVER: begin
                resp0_valid = !owner;
                resp1_valid = owner;
            end
            default: ;
        endcase
    end

    // Always ready: outside S_RESP this silently drains late replies from the DM.
    assign dm_resp_ready = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio    <= 1'b0;
            owner   <= 1'b0;
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                owner   <= grant1;
                prio    <= !grant1;
                addr_q  <= grant1 ? req1_addr : req0_addr;
                op_q    <= grant1 ? req1_op   : req0_op;
                wdata_q <= grant1 ? req1_data : req0_data;
            end
            case (state)
                S_REQ: if (dm_req_ready) cnt <= '0;
                S_RESP: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (dm_resp_valid) begin
                        resp_q  <= dm_resp_resp;
                        rdata_q <= dm_resp_data;
                    end else if (timeout_hit) begin
                        resp_q  <= 2'd2;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dm_req_addr = addr_q;
    assign dm_req_op   = op_q;
    assign dm_req_data = wdata_q;
    assign resp0_resp  = resp_q;
    assign resp0_data  = rdata_q;
    assign resp1_resp  = resp_q;
    assign resp1_data  = rdata_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter: arbitration order, request stall, timeout, response
// back-pressure and mid-transaction reset, with hand-derived expectations.
module tb_dmi_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0]  req0_addr, req1_addr;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [1:0]  resp0_resp, resp1_resp;
    logic [31:0] resp0_data, resp1_data;
    logic        dm_req_valid, dm_req_ready;
    logic [6:0]  dm_req_addr;
    logic [1:0]  dm_req_op;
    logic [31:0] dm_req_data;
    logic        dm_resp_valid, dm_resp_ready;
    logic [1:0]  dm_resp_resp;
    logic [31:0] dm_resp_data;
    logic        timeout_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmi_arbiter #(.ADDR_W(7), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_op(req0_op), .req0_data(req0_data),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_resp(resp0_resp),
        .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_op(req1_op), .req1_data(req1_data),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_resp(resp1_resp),
        .resp1_data(resp1_data),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
        .dm_req_op(dm_req_op), .dm_req_data(dm_req_data),
        .dm_resp_valid(dm_resp_valid), .dm_resp_ready(dm_resp_ready),
        .dm_resp_resp(dm_resp_resp), .dm_resp_data(dm_resp_data),
        .timeout_pulse(timeout_pulse)
    );

    // Inputs change just after the rising edge; outputs are looked at on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        req0_valid    = 1'b0;
        req1_valid    = 1'b0;
        dm_req_ready  = 1'b0;
        dm_resp_valid = 1'b0;
        resp0_ready   = 1'b1;
        resp1_ready   = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        smp();
        total++;
        if ({req0_ready, req1_ready, dm_req_valid, resp0_valid, resp1_valid, timeout_pulse, dm_resp_ready} !== 7'b0000001) begin
            bad++;
            $display("FAIL reset_ctrl got r0r=%b r1r=%b dmv=%b v0=%b v1=%b to=%b dmrr=%b want 0000001",
                     req0_ready, req1_ready, dm_req_valid, resp0_valid, resp1_valid, timeout_pulse, dm_resp_ready);
        end
        total++;
        if ({dm_req_addr, dm_req_op, dm_req_data, resp0_resp, resp0_data} !== '0) begin
            bad++;
            $display("FAIL reset_data got addr=%h op=%h data=%h resp=%h rdata=%h want all 0",
                     dm_req_addr, dm_req_op, dm_req_data, resp0_resp, resp0_data);
        end
        step();
    endtask

    task automatic test_single_read();
        req0_valid = 1'b1; req0_addr = 7'h11; req0_op = 2'd1; req0_data = 32'h0;
        dm_req_ready = 1'b1;
        smp();
        total++;
        if ({req0_ready, req1_ready, dm_req_valid} !== 3'b100) begin
            bad++;
            $display("FAIL read_accept got r0r=%b r1r=%b dmv=%b want 1 0 0", req0_ready, req1_ready, dm_req_valid);
        end
        step();
        req0_valid = 1'b0;
        smp();
        total++;
        if ({dm_req_valid, dm_req_addr, dm_req_op} !== {1'b1, 7'h11, 2'd1}) begin
            bad++;
            $display("FAIL read_dmreq got v=%b addr=%h op=%h want 1 11 1", dm_req_valid, dm_req_addr, dm_req_op);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            smp();
            total++;
            if ({dm_resp_ready, resp0_valid, dm_req_valid} !== 3'b100) begin
                bad++;
                $display("FAIL read_wait%0d got dmrr=%b v0=%b dmv=%b want 1 0 0", i, dm_resp_ready, resp0_valid, dm_req_valid);
            end
            step();
        end
        dm_resp_valid = 1'b1; dm_resp_resp = 2'd0; dm_resp_data = 32'hDEADBEEF;
        smp();
        step();
        dm_resp_valid = 1'b0;
        smp();
        total++;
        if ({resp0_valid, resp1_valid, resp0_resp, resp0_data} !== {1'b1, 1'b0, 2'd0, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL read_resp got v0=%b v1=%b resp=%h data=%h want 1 0 0 deadbeef",
                     resp0_valid, resp1_valid, resp0_resp, resp0_data);
        end
        step();
        smp();
        total++;
        if (resp0_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_done got v0=%b want 0", resp0_valid);
        end
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        req0_addr = 7'h20; req0_op = 2'd1; req0_data = 32'h0;
        req1_addr = 7'h30; req1_op = 2'd1; req1_data = 32'h0;
        req0_valid = 1'b1; req1_valid = 1'b1; dm_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            automatic bit p1 = (k % 2) == 1;
            smp();
            total++;
            if ({req0_ready, req1_ready} !== (p1 ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL rr_grant%0d got r0r=%b r1r=%b want port %0d", k, req0_ready, req1_ready, p1);
            end
            step();
            smp();
            total++;
            if ({dm_req_valid, dm_req_addr, req0_ready, req1_ready} !== {1'b1, (p1 ? 7'h30 : 7'h20), 2'b00}) begin
                bad++;
                $display("FAIL rr_dmreq%0d got v=%b addr=%h r0r=%b r1r=%b", k, dm_req_valid, dm_req_addr, req0_ready, req1_ready);
            end
            step();
            dm_resp_valid = 1'b1; dm_resp_resp = 2'd0; dm_resp_data = 32'h1000 + k;
            step();
            dm_resp_valid = 1'b0;
            smp();
            total++;
            if ({resp0_valid, resp1_valid, resp0_data, req0_ready, req1_ready} !==
                {(p1 ? 2'b01 : 2'b10), 32'h1000 + k, 2'b00}) begin
                bad++;
                $display("FAIL rr_resp%0d got v0=%b v1=%b data=%h r0r=%b r1r=%b", k,
                         resp0_valid, resp1_valid, resp0_data, req0_ready, req1_ready);
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_req_stall();
        do_reset();
        req0_valid = 1'b1; req0_addr = 7'h05; req0_op = 2'd2; req0_data = 32'hA5A50001;
        dm_req_ready = 1'b0;
        smp();
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_accept got r0r=%b want 1", req0_ready);
        end
        step();
        req0_valid = 1'b0; req0_addr = 7'h7F; req0_op = 2'd0; req0_data = 32'h0;
        for (int i = 0; i < 5; i++) begin
            smp();
            total++;
            if ({dm_req_valid, dm_req_addr, dm_req_op, dm_req_data} !== {1'b1, 7'h05, 2'd2, 32'hA5A50001}) begin
                bad++;
                $display("FAIL stall_hold%0d got v=%b addr=%h op=%h data=%h want 1 05 2 a5a50001",
                         i, dm_req_valid, dm_req_addr, dm_req_op, dm_req_data);
            end
            step();
        end
        dm_req_ready = 1'b1;
        step();
        dm_resp_valid = 1'b1; dm_resp_resp = 2'd0; dm_resp_data = 32'h5555AAAA;
        step();
        dm_resp_valid = 1'b0;
        smp();
        total++;
        if ({resp0_valid, resp0_data} !== {1'b1, 32'h5555AAAA}) begin
            bad++;
            $display("FAIL stall_resp got v0=%b data=%h want 1 5555aaaa", resp0_valid, resp0_data);
        end
        step();
    endtask

    task automatic test_timeout();
        req1_valid = 1'b1; req1_addr = 7'h40; req1_op = 2'd1; req1_data = 32'h0;
        dm_req_ready = 1'b1;
        smp();
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++;
            $display("FAIL to_accept got r0r=%b r1r=%b want 0 1", req0_ready, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            smp();
            total++;
            if ({timeout_pulse, resp1_valid} !== {(i == 7), 1'b0}) begin
                bad++;
                $display("FAIL to_wait%0d got pulse=%b v1=%b want %0d 0", i, timeout_pulse, resp1_valid, i == 7);
            end
            step();
        end
        smp();
        total++;
        if ({resp1_valid, resp0_valid, resp1_resp, resp1_data, timeout_pulse} !== {2'b10, 2'd2, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL to_resp got v1=%b v0=%b resp=%h data=%h pulse=%b want 1 0 2 0 0",
                     resp1_valid, resp0_valid, resp1_resp, resp1_data, timeout_pulse);
        end
        step();
        step();
        step();
        dm_resp_valid = 1'b1; dm_resp_resp = 2'd0; dm_resp_data = 32'hBAD0BAD0;
        smp();
        total++;
        if ({dm_resp_ready, resp0_valid, resp1_valid} !== 3'b100) begin
            bad++;
            $display("FAIL stale_take got dmrr=%b v0=%b v1=%b want 1 0 0", dm_resp_ready, resp0_valid, resp1_valid);
        end
        step();
        dm_resp_valid = 1'b0;
        smp();
        total++;
        if ({resp0_valid, resp1_valid, dm_req_valid} !== 3'b000) begin
            bad++;
            $display("FAIL stale_drop got v0=%b v1=%b dmv=%b want 0 0 0", resp0_valid, resp1_valid, dm_req_valid);
        end
        step();
        req0_valid = 1'b1; req0_addr = 7'h41; req0_op = 2'd1;
        step();
        req0_valid = 1'b0;
        step();
        dm_resp_valid = 1'b1; dm_resp_resp = 2'd0; dm_resp_data = 32'h77;
        step();
        dm_resp_valid = 1'b0;
        smp();
        total++;
        if ({resp0_valid, resp0_resp, resp0_data} !== {1'b1, 2'd0, 32'h77}) begin
            bad++;
            $display("FAIL after_stale got v0=%b resp=%h data=%h want 1 0 77", resp0_valid, resp0_resp, resp0_data);
        end
        step();
    endtask

    task automatic test_resp_hold();
        do_reset();
        resp1_ready = 1'b0;
        req1_valid = 1'b1; req1_addr = 7'h12; req1_op = 2'd1;
        dm_req_ready = 1'b1;
        smp();
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++;
            $display("FAIL hold_accept got r0r=%b r1r=%b want 0 1", req0_ready, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 7'h13; req0_op = 2'd1;
        smp();
        total++;
        if ({req0_ready, dm_req_valid, dm_req_addr} !== {2'b01, 7'h12}) begin
            bad++;
            $display("FAIL hold_req got r0r=%b dmv=%b addr=%h want 0 1 12", req0_ready, dm_req_valid, dm_req_addr);
        end
        step();
        dm_resp_valid = 1'b1; dm_resp_resp = 2'd3; dm_resp_data = 32'hCAFE0005;
        step();
        dm_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            total++;
            if ({resp1_valid, resp1_resp, resp1_data, resp0_valid, req0_ready} !== {1'b1, 2'd3, 32'hCAFE0005, 2'b00}) begin
                bad++;
                $display("FAIL hold_stable%0d got v1=%b resp=%h data=%h v0=%b r0r=%b want 1 3 cafe0005 0 0",
                         i, resp1_valid, resp1_resp, resp1_data, resp0_valid, req0_ready);
            end
            step();
        end
        resp1_ready = 1'b1;
        smp();
        total++;
        if ({resp1_valid, req0_ready} !== 2'b10) begin
            bad++;
            $display("FAIL hold_handshake got v1=%b r0r=%b want 1 0", resp1_valid, req0_ready);
        end
        step();
        smp();
        total++;
        if ({req0_ready, resp1_valid} !== 2'b10) begin
            bad++;
            $display("FAIL hold_next_accept got r0r=%b v1=%b want 1 0", req0_ready, resp1_valid);
        end
        step();
        req0_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1'b1; req0_addr = 7'h22; req0_op = 2'd1;
        dm_req_ready = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        smp();
        total++;
        if ({dm_req_valid, resp0_valid, resp1_valid, timeout_pulse, dm_resp_ready, dm_req_addr} !== {5'b00001, 7'h00}) begin
            bad++;
            $display("FAIL midreset_out got dmv=%b v0=%b v1=%b pulse=%b dmrr=%b addr=%h want 0 0 0 0 1 00",
                     dm_req_valid, resp0_valid, resp1_valid, timeout_pulse, dm_resp_ready, dm_req_addr);
        end
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        smp();
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL midreset_tie got r0r=%b r1r=%b want 1 0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_op = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_op = '0; req1_data = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        dm_req_ready = 1'b0;
        dm_resp_valid = 1'b0; dm_resp_resp = '0; dm_resp_data = '0;

        test_reset();
        test_single_read();
        test_round_robin();
        test_req_stall();
        test_timeout();
        test_resp_hold();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
